// File: rtl/mpsoc_ahb3_spram_master.sv
// AHB3-Lite master front end for the SPRAM slave port.
// Turns a valid/ready request stream into pipelined SINGLE transfers and
// returns exactly one response per request, in acceptance order.
// Pipeline: p0 = address phase, p1 = data phase, p2 = response register.
module mpsoc_ahb3_spram_master #(
  parameter int         PLEN      = 8,
  parameter int         XLEN      = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic            HCLK,
  input  logic            HRESETn,

  input  logic            req_valid,
  output logic            req_ready,
  input  logic [PLEN-1:0] req_addr,
  input  logic            req_write,
  input  logic [2:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,

  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            busy,

  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));

  // Sizes wider than the data bus saturate to the full bus width.
  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (s > MAX_SIZE) ? MAX_SIZE : s;
  endfunction

  logic            r_vld_p0, r_write_p0, r_vld_p1, r_write_p1;
  logic            r_err, r_trans_p0, r_vld_p2, r_err_p2;
  logic [PLEN-1:0] r_addr_p0;
  logic [2:0]      r_size_p0;
  logic [XLEN-1:0] r_wdata_p0, r_wdata_p1, r_rdata_p2;

  logic            w_accept;
  logic            w_vld_p0, w_write_p0, w_vld_p1, w_write_p1;
  logic            w_err, w_vld_p2, w_err_p2;
  logic [PLEN-1:0] w_addr_p0;
  logic [2:0]      w_size_p0;
  logic [XLEN-1:0] w_wdata_p0, w_wdata_p1, w_rdata_p2;

  assign req_ready = !r_err && (!r_vld_p0 || HREADY);
  assign w_accept  = req_valid && req_ready;
  assign busy      = r_vld_p0 || r_vld_p1 || r_err;

  assign HSEL      = r_trans_p0;
  assign HTRANS    = r_trans_p0 ? 2'b10 : 2'b00;
  assign HADDR     = r_addr_p0;
  assign HWRITE    = r_write_p0;
  assign HSIZE     = r_size_p0;
  assign HWDATA    = r_wdata_p1;
  assign HBURST    = 3'b000;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;

  assign rsp_valid = r_vld_p2;
  assign rsp_rdata = r_rdata_p2;
  assign rsp_err   = r_err_p2;

  // Next-state of all pipeline stages, error flag and response register.
  always_comb begin
    w_vld_p0   = r_vld_p0;
    w_addr_p0  = r_addr_p0;
    w_write_p0 = r_write_p0;
    w_size_p0  = r_size_p0;
    w_wdata_p0 = r_wdata_p0;
    w_vld_p1   = r_vld_p1;
    w_write_p1 = r_write_p1;
    w_wdata_p1 = r_wdata_p1;
    w_err      = r_err;
    w_vld_p2   = 1'b0;
    w_rdata_p2 = '0;
    w_err_p2   = 1'b0;

    if (r_err) begin
      // Second error cycle: retire the failed data phase, keep p0 parked.
      if (HREADY) begin
        w_vld_p2 = r_vld_p1;
        w_err_p2 = 1'b1;
        w_vld_p1 = 1'b0;
        w_err    = 1'b0;
      end
    end else if (HREADY) begin
      // p1 -> p2: data phase completes
      if (r_vld_p1) begin
        w_vld_p2   = 1'b1;
        w_err_p2   = HRESP;
        w_rdata_p2 = (!r_write_p1 && !HRESP) ? HRDATA : '0;
      end
      // p0 -> p1: address phase advances
      w_vld_p1 = r_vld_p0;
      if (r_vld_p0) begin
        w_write_p1 = r_write_p0;
        if (r_write_p0) w_wdata_p1 = r_wdata_p0;
      end
      w_vld_p0 = 1'b0;
    end else if (r_vld_p1 && HRESP) begin
      // First error cycle: withdraw the pending address phase next cycle.
      w_err = 1'b1;
    end

    if (w_accept) begin
      w_vld_p0   = 1'b1;
      w_addr_p0  = req_addr;
      w_write_p0 = req_write;
      w_size_p0  = clamp_size(req_size);
      w_wdata_p0 = req_wdata;
    end
  end

  // State registers; reset empties the pipeline and idles the bus at once.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_vld_p0   <= 1'b0;
      r_addr_p0  <= '0;
      r_write_p0 <= 1'b0;
      r_size_p0  <= 3'b000;
      r_wdata_p0 <= '0;
      r_trans_p0 <= 1'b0;
      r_vld_p1   <= 1'b0;
      r_write_p1 <= 1'b0;
      r_wdata_p1 <= '0;
      r_err      <= 1'b0;
      r_vld_p2   <= 1'b0;
      r_rdata_p2 <= '0;
      r_err_p2   <= 1'b0;
    end else begin
      r_vld_p0   <= w_vld_p0;
      r_addr_p0  <= w_addr_p0;
      r_write_p0 <= w_write_p0;
      r_size_p0  <= w_size_p0;
      r_wdata_p0 <= w_wdata_p0;
      r_trans_p0 <= w_vld_p0 && !w_err;
      r_vld_p1   <= w_vld_p1;
      r_write_p1 <= w_write_p1;
      r_wdata_p1 <= w_wdata_p1;
      r_err      <= w_err;
      r_vld_p2   <= w_vld_p2;
      r_rdata_p2 <= w_rdata_p2;
      r_err_p2   <= w_err_p2;
    end
  end

endmodule
